// File: rtl/fpu_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_request_arbiter_pkg
// Description : Shared opcodes, FSM state encoding, default parameters and a
//               per-opcode latency helper for the FPU request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_request_arbiter_pkg;

    // Opcode encoding understood by the Fixed_Point_Unit.
    typedef enum logic [1:0] {
        FPU_ADD  = 2'b00,
        FPU_SUB  = 2'b01,
        FPU_MUL  = 2'b10,
        FPU_SQRT = 2'b11
    } fpu_op_t;

    // Opcode presented while no operation is in flight. ADD is purely
    // combinational inside the FPU, so the MUL/SQRT machines stay parked.
    localparam fpu_op_t FPU_IDLE_OP = FPU_ADD;

    // Default configuration.
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_REQ  = 2;
    localparam int DEF_MUL_LAT  = 6;
    localparam int DEF_SQRT_LAT = 35;
    localparam int DEF_TIMEOUT  = 64;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Minimum number of edges an opcode must be applied before the FPU's
    // ready flag can be trusted (ready is sticky from earlier operations).
    function automatic int op_latency(input logic [1:0] op,
                                      input int         mul_lat,
                                      input int         sqrt_lat);
        int lat;
        case (op)
            FPU_MUL:  lat = mul_lat;
            FPU_SQRT: lat = sqrt_lat;
            default:  lat = 0;
        endcase
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_rr_arbiter
// Description : Combinational round-robin picker. The winner is the first
//               asserted request strictly after rr_ptr, wrapping around, so
//               the previous winner has lowest priority.
// Revision    : 1.0 - initial release
// Ports       : req        in  NUM_REQ  request vector
//               rr_ptr     in  IDX_W    index of the previous winner
//               grant      out NUM_REQ  one-hot grant (all zero if no request)
//               grant_idx  out IDX_W    index of the granted request
// ============================================================================
module fpu_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;
    int   cand;

    // Scan offsets 1..NUM_REQ from the pointer; offset NUM_REQ is the
    // previous winner itself, which therefore wins only when it is alone.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_request_arbiter
// Description : Shares one Fixed_Point_Unit between NUM_REQ requesters.
//               Accepts one request at a time (round-robin), holds the
//               opcode/operands on the FPU for the whole operation, decides
//               completion from a per-opcode minimum latency plus fpu_ready,
//               and returns the result tagged to the owning requester.
// Revision    : 1.0 - initial release
// Ports       : clk, reset (asynchronous, active-high)
//               req_valid/req_ready/req_op/req_opa/req_opb  requester side
//               rsp_valid/rsp_data/rsp_err                 response side
//               busy                                       EXEC or RESP
//               fpu_operand_1/2, fpu_operation, fpu_result, fpu_ready
// ============================================================================
module fpu_request_arbiter
    import fpu_request_arbiter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int SQRT_LAT = DEF_SQRT_LAT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_opa,
    input  logic [WIDTH*NUM_REQ-1:0] req_opb,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [WIDTH-1:0]         fpu_operand_1,
    output logic [WIDTH-1:0]         fpu_operand_2,
    output logic [1:0]               fpu_operation,
    input  logic [WIDTH-1:0]         fpu_result,
    input  logic                     fpu_ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   id_q;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_opa;
    logic [WIDTH-1:0]   sel_opb;
    logic [CNT_W-1:0]   lat;
    logic               exec_done;
    logic               exec_timeout;
    logic [NUM_REQ-1:0] id_onehot;

    fpu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Operand/opcode slice of the current winner.
    always_comb begin
        sel_op  = req_op[2*int'(grant_idx) +: 2];
        sel_opa = req_opa[WIDTH*int'(grant_idx) +: WIDTH];
        sel_opb = req_opb[WIDTH*int'(grant_idx) +: WIDTH];
    end

    // The fpu_* registers hold the latched request for the whole of EXEC,
    // so the latency lookup can use them directly.
    always_comb begin
        lat          = CNT_W'(op_latency(fpu_operation, MUL_LAT, SQRT_LAT));
        exec_done    = (cnt >= lat) && fpu_ready;
        exec_timeout = (cnt == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        id_onehot       = '0;
        id_onehot[id_q] = 1'b1;
    end

    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            id_q          <= '0;
            cnt           <= '0;
            fpu_operation <= FPU_IDLE_OP;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        fpu_operation <= sel_op;
                        fpu_operand_1 <= sel_opa;
                        fpu_operand_2 <= sel_opb;
                        id_q          <= grant_idx;
                        rr_ptr        <= grant_idx;
                        cnt           <= '0;
                        state         <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // cnt never wraps: the timeout exit fires at TIMEOUT-1.
                    cnt <= cnt + 1'b1;
                    if (exec_done || exec_timeout) begin
                        rsp_valid     <= id_onehot;
                        rsp_data      <= exec_done ? fpu_result : '0;
                        rsp_err       <= !exec_done;
                        fpu_operation <= FPU_IDLE_OP;
                        fpu_operand_1 <= '0;
                        fpu_operand_2 <= '0;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // rsp_data deliberately keeps the last result.
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
